// File: rtl/recv_credit_fifo.sv
// Receive-side credit FIFO: buffers words pushed by the upstream receiver
// and returns one credit per popped word. Optional overflow flag via RECV_FIFO_OVF_CHECK_EN.
module recv_credit_fifo #(
    parameter int DATA_WIDTH   = 64,
    parameter int DEPTH        = 4,
    parameter int CREDIT_WIDTH = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    in_valid,
    input  logic [DATA_WIDTH-1:0]   in_data,
    output logic                    out_valid,
    output logic [DATA_WIDTH-1:0]   out_data,
    input  logic                    out_ready,
    output logic                    credit_return,
    output logic [CREDIT_WIDTH-1:0] free_slots,
    output logic                    ovf_err
);

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CREDIT_WIDTH-1:0] DEPTH_C = CREDIT_WIDTH'(DEPTH);
    localparam logic [CREDIT_WIDTH-1:0] CNT_ONE = CREDIT_WIDTH'(1);
    localparam logic [PTR_W-1:0]        PTR_ONE = PTR_W'(1);

    logic [DATA_WIDTH-1:0]   mem [DEPTH];
    logic [PTR_W-1:0]        wr_ptr;
    logic [PTR_W-1:0]        rd_ptr;
    logic [CREDIT_WIDTH-1:0] count;
    logic                    full;
    logic                    push;
    logic                    pop;

    assign full       = (count == DEPTH_C);
    assign out_valid  = (count != '0);
    assign pop        = out_valid & out_ready;
    // A full FIFO still accepts a word when the head leaves in the same cycle.
    assign push       = in_valid & (~full | pop);
    assign out_data   = mem[rd_ptr];
    assign free_slots = DEPTH_C - count;

    // Storage write; nothing is captured while reset is held.
    always_ff @(posedge clk) begin
        if (rst_n && push) begin
            mem[wr_ptr] <= in_data;
        end
    end

    // Pointers, occupancy and the registered credit pulse.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr        <= '0;
            rd_ptr        <= '0;
            count         <= '0;
            credit_return <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            unique case ({push, pop})
                2'b10:   count <= count + CNT_ONE;
                2'b01:   count <= count - CNT_ONE;
                default: count <= count;
            endcase
            credit_return <= pop;
        end
    end

`ifdef RECV_FIFO_OVF_CHECK_EN
    logic ovf_q;

    // Sticky flag for a word that arrived with no room and no pop to make room.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else if (in_valid && full && !pop) begin
            ovf_q <= 1'b1;
`ifndef SYNTHESIS
            $display("ERROR: recv_credit_fifo overflow, word %h dropped", in_data);
`endif
        end
    end

    assign ovf_err = ovf_q;
`else
    assign ovf_err = 1'b0;
`endif

endmodule
